instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 reset  in  1  reset, synchronous, active-high.
REQ-003 in_valid  in  1  field set presented; in_ready  out  1  encoder can accept.
REQ-004 fmt  in  2  format select: 0=R, 1=I, 2=J, 3=invalid.
REQ-005 instrOP  in  4 | opcode  in  4 | ce  in  1 | oe  in  1  instruction fields.
REQ-006 const11  in  11 | const16  in  16 | const27  in  27  constant fields.
REQ-007 areg, breg, dreg  in  4 each  register fields.
REQ-008 base_addr  in  27 | base_load  in  1  load write pointer.
REQ-009 mem_addr  out  27 | mem_data  out  32 | mem_we  out  1 | mem_busy  in  1  memory write port.
REQ-010 idle  out  1  FIFO empty and write FSM in IDLE; fmt_err  out  1  one-cycle pulse on invalid fmt.
REQ-011 err_cnt  out  8  rejected-word count (only with INSTR_ENC_ERRCNT_EN).

Function
REQ-012 Packing SHALL be: R = {instrOP[31:28], ce[27], opcode[26:23], const11[22:12], areg[11:8], breg[7:4], dreg[3:0]}.
REQ-013 I = {instrOP[31:28], const16[27:12], areg[11:8], breg[7:4], dreg[3:0]}.
REQ-014 J = {instrOP[31:28], const27[27:1], oe[0]}.
REQ-015 A transfer SHALL occur on a rising edge where in_valid && in_ready; fields are sampled only then.
REQ-016 fmt=3 on a transfer SHALL push nothing and pulse fmt_err the following cycle.
REQ-017 The packed word SHALL enter a 4-entry FIFO; in_ready = (occupancy < 4), independent of same-cycle pop.
REQ-018 Write FSM states: IDLE, WRITE.
- IDLE->WRITE when FIFO non-empty.
- WRITE->IDLE on completion with FIFO empty after pop.
- WRITE->WRITE on completion with FIFO still non-empty.
REQ-019 In WRITE, mem_we=1 with mem_data = FIFO head and mem_addr = write pointer, all held stable.
REQ-020 A write completes on a WRITE-state edge with mem_busy=0: FIFO pops and the write pointer increments by 1.
REQ-021 The write pointer SHALL wrap from 27'h7FFFFFF to 0.
REQ-022 Latency: a word accepted at edge N into an empty FIFO with the FSM in IDLE shows mem_we=1 in cycle N+1.
- Back-to-back completions SHALL sustain one word per cycle while mem_busy=0.
REQ-023 base_load SHALL update the write pointer only when idle=1; otherwise it is ignored.
- base_load with a same-edge transfer: the pointer loads; the word is written at the new pointer.
REQ-024 mem_busy is sampled only in WRITE; it has no effect in IDLE.

Reset
REQ-025 On reset: FIFO empty, FSM in IDLE, write pointer=0, mem_we=0, mem_data=0, mem_addr=0, fmt_err=0, err_cnt=0.
- Consequently in_ready=1 and idle=1.
REQ-026 Reset during WRITE SHALL deassert mem_we on the next edge and discard all buffered words.

Configuration
REQ-027 Macro INSTR_ENC_ERRCNT_EN defined: err_cnt increments on each fmt=3 transfer and saturates at 255.
REQ-028 Macro INSTR_ENC_ERRCNT_EN undefined: err_cnt is absent from the port list; all other behaviour is identical.

Verification
REQ-029 Reset, base_load=1 with base_addr=0x100, then R transfer (instrOP=1, ce=1, opcode=5, const11=0x7FF, areg=2, breg=3, dreg=4) with mem_busy=0 -> one-cycle mem_we, mem_data=0x1AFFF234, mem_addr=0x100.
REQ-030 I transfer (instrOP=3, const16=0xBEEF, areg=1, breg=2, dreg=3) then J transfer (instrOP=9, const27=0x5555555, oe=1), mem_busy=0 -> consecutive writes 0x3BEEF123 then 0x9AAAAAAB at consecutive addresses.
REQ-031 mem_busy=1 held, 5 valid transfers -> first 4 accepted, in_ready=0 on the 5th; release mem_busy -> 4 writes in order, then idle=1.
REQ-032 fmt=3 transfer -> no mem_we, fmt_err pulse; with INSTR_ENC_ERRCNT_EN, 300 such transfers -> err_cnt=255.
REQ-033 base_addr=0x7FFFFFF, two writes -> addresses 0x7FFFFFF then 0x0000000.
REQ-034 Reset asserted during WRITE with 3 words queued -> mem_we=0 next cycle, idle=1, no further writes.

Source files
------------

// File: rtl/instr_encoder.sv
// Instruction encoder: packs R/I/J field sets into 32-bit words, buffers them
// in a 4-entry FIFO and writes them to memory at an auto-incrementing pointer.
// Latency: word accepted at edge N (empty FIFO, FSM idle) drives mem_we from edge N+1.
// Backpressure: in_ready drops when 4 words are held (including the one being
// written); mem_busy stalls the current write.
// Optional feature: define INSTR_ENC_ERRCNT_EN to add the saturating err_cnt port.
module instr_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  fmt,
  input  logic [3:0]  instrOP,
  input  logic [3:0]  opcode,
  input  logic        ce,
  input  logic        oe,
  input  logic [10:0] const11,
  input  logic [15:0] const16,
  input  logic [26:0] const27,
  input  logic [3:0]  areg,
  input  logic [3:0]  breg,
  input  logic [3:0]  dreg,
  input  logic [26:0] base_addr,
  input  logic        base_load,
  output logic [26:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        mem_we,
  input  logic        mem_busy,
  output logic        idle,
`ifdef INSTR_ENC_ERRCNT_EN
  output logic [7:0]  err_cnt,
`endif
  output logic        fmt_err
);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t      state;
  logic [31:0] fifo_mem [4];
  logic [1:0]  rd_ptr;
  logic [1:0]  wr_ptr;
  logic [2:0]  count;
  logic [26:0] wptr;

  logic        xfer;
  logic        push;
  logic        pop;
  logic        has_next;
  logic [31:0] packed_word;
  logic [31:0] next_head;

  // Occupancy counts the word under write, so ready ignores a same-cycle pop.
  assign in_ready = (count < 3'd4);
  assign idle     = (state == IDLE) && (count == 3'd0);
  assign xfer     = in_valid && in_ready;
  assign push     = xfer && (fmt != 2'd3);
  assign pop      = (state == WRITE) && !mem_busy;

  // Pack the presented fields according to the selected format.
  always_comb begin
    packed_word = 32'd0;
    case (fmt)
      2'd0:    packed_word = {instrOP, ce, opcode, const11, areg, breg, dreg};
      2'd1:    packed_word = {instrOP, const16, areg, breg, dreg};
      2'd2:    packed_word = {instrOP, const27, oe};
      default: packed_word = 32'd0;
    endcase
  end

  // Word that becomes the head after a pop: the next stored entry, or the
  // word being pushed on the same edge when the popped entry was the last one.
  always_comb begin
    has_next  = (count > 3'd1) || push;
    next_head = (count > 3'd1) ? fifo_mem[rd_ptr + 2'd1] : packed_word;
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= packed_word;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // Write FSM with registered memory-port outputs and the write pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      mem_we   <= 1'b0;
      mem_data <= 32'd0;
      mem_addr <= 27'd0;
      wptr     <= 27'd0;
    end else begin
      case (state)
        IDLE: begin
          // idle implies an empty FIFO, so a pointer load never races a write start
          if (base_load && idle) begin
            wptr <= base_addr;
          end
          if (count != 3'd0) begin
            state    <= WRITE;
            mem_we   <= 1'b1;
            mem_data <= fifo_mem[rd_ptr];
            mem_addr <= wptr;
          end
        end
        WRITE: begin
          if (!mem_busy) begin
            wptr <= wptr + 27'd1;
            if (has_next) begin
              mem_data <= next_head;
              mem_addr <= wptr + 27'd1;
            end else begin
              state  <= IDLE;
              mem_we <= 1'b0;
            end
          end
        end
        default: begin
          state  <= IDLE;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

  // One-cycle error pulse for a transfer carrying the invalid format.
  always_ff @(posedge clk) begin
    if (reset) begin
      fmt_err <= 1'b0;
    end else begin
      fmt_err <= xfer && (fmt == 2'd3);
    end
  end

`ifdef INSTR_ENC_ERRCNT_EN
  // Saturating count of rejected words.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt <= 8'd0;
    end else if (xfer && (fmt == 2'd3) && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed transfers, expected memory writes pushed
// into a queue at issue time and compared by an independent write monitor.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  fmt;
  logic [3:0]  instrOP;
  logic [3:0]  opcode;
  logic        ce;
  logic        oe;
  logic [10:0] const11;
  logic [15:0] const16;
  logic [26:0] const27;
  logic [3:0]  areg;
  logic [3:0]  breg;
  logic [3:0]  dreg;
  logic [26:0] base_addr;
  logic        base_load;
  logic [26:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_we;
  logic        mem_busy;
  logic        idle;
  logic        fmt_err;
`ifdef INSTR_ENC_ERRCNT_EN
  logic [7:0]  err_cnt;
`endif

  instr_encoder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .instrOP(instrOP), .opcode(opcode), .ce(ce), .oe(oe),
    .const11(const11), .const16(const16), .const27(const27),
    .areg(areg), .breg(breg), .dreg(dreg),
    .base_addr(base_addr), .base_load(base_load),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_busy(mem_busy),
    .idle(idle),
`ifdef INSTR_ENC_ERRCNT_EN
    .err_cnt(err_cnt),
`endif
    .fmt_err(fmt_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int wr_count = 0;
  int last_wr_cyc = 0;
  int prev_wr_cyc = 0;

  logic [58:0] exp_q [$];     // {addr, data}
  logic [26:0] exp_ptr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
  endtask

  // Monitor: a write completes on the coming edge when mem_we && !mem_busy and
  // reset is not asserted; inputs are stable at the falling edge.
  always @(negedge clk) begin
    logic [58:0] e;
    cyc++;
    if (mem_we && !mem_busy && !reset) begin
      wr_count++;
      prev_wr_cyc = last_wr_cyc;
      last_wr_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_write", {5'd0, mem_addr, mem_data}, 64'hDEAD);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", {37'd0, mem_addr}, {37'd0, e[58:32]});
        check("wr_data", {32'd0, mem_data}, {32'd0, e[31:0]});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_r(input logic [3:0] op, input logic c, input logic [3:0] opc,
                       input logic [10:0] k, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] d);
    instrOP = op; ce = c; opcode = opc; const11 = k; areg = a; breg = b; dreg = d;
  endtask

  task automatic set_i(input logic [3:0] op, input logic [15:0] k,
                       input logic [3:0] a, input logic [3:0] b, input logic [3:0] d);
    instrOP = op; const16 = k; areg = a; breg = b; dreg = d;
  endtask

  task automatic set_j(input logic [3:0] op, input logic [26:0] k, input logic o);
    instrOP = op; const27 = k; oe = o;
  endtask

  // Present one field set, wait (bounded) for ready, transfer on one edge.
  task automatic xfer(input logic [1:0] f, input logic [31:0] word);
    int guard = 0;
    fmt = f;
    in_valid = 1'b1;
    while (!in_ready && guard < 200) begin
      tick();
      guard++;
    end
    if (guard >= 200) check("in_ready_timeout", 64'd0, 64'd1);
    if (f != 2'd3) begin
      exp_q.push_back({exp_ptr, word});
      exp_ptr = exp_ptr + 27'd1;
    end
    tick();
    in_valid  = 1'b0;
    base_load = 1'b0;
  endtask

  task automatic wait_idle;
    int guard = 0;
    while (!idle && guard < 200) begin
      tick();
      guard++;
    end
    if (guard >= 200) check("idle_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
    exp_ptr = 27'd0;
  endtask

  initial begin
    int wc;
    reset = 1'b0; in_valid = 1'b0; fmt = 2'd0; base_load = 1'b0; base_addr = 27'd0;
    mem_busy = 1'b0; exp_ptr = 27'd0;
    set_r(0, 0, 0, 0, 0, 0, 0); set_i(0, 0, 0, 0, 0); set_j(0, 0, 0);
    do_reset();

    // Reset state
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_idle",     {63'd0, idle},     64'd1);
    check("rst_mem_we",   {63'd0, mem_we},   64'd0);
    check("rst_mem_addr", {37'd0, mem_addr}, 64'd0);
    check("rst_mem_data", {32'd0, mem_data}, 64'd0);
    check("rst_fmt_err",  {63'd0, fmt_err},  64'd0);
`ifdef INSTR_ENC_ERRCNT_EN
    check("rst_err_cnt",  {56'd0, err_cnt},  64'd0);
`endif

    // R word with a same-edge pointer load to 0x100
    base_addr = 27'h100; base_load = 1'b1; exp_ptr = 27'h100;
    set_r(4'd1, 1'b1, 4'd5, 11'h7FF, 4'd2, 4'd3, 4'd4);
    xfer(2'd0, 32'h1AFFF234);
    check("lat_we_n", {63'd0, mem_we}, 64'd0);
    tick();
    check("lat_we_n1", {63'd0, mem_we}, 64'd1);
    check("lat_addr", {37'd0, mem_addr}, 64'h100);
    tick();
    check("we_one_cycle", {63'd0, mem_we}, 64'd0);
    wait_idle();

    // I then J back to back at consecutive addresses, consecutive cycles
    set_i(4'd3, 16'hBEEF, 4'd1, 4'd2, 4'd3);
    xfer(2'd1, 32'h3BEEF123);
    set_j(4'd9, 27'h5555555, 1'b1);
    xfer(2'd2, 32'h9AAAAAAB);
    wait_idle();
    check("b2b_gap", last_wr_cyc - prev_wr_cyc, 64'd1);

    // Stalled memory: 4 accepted, 5th refused; pointer load ignored while busy
    mem_busy = 1'b1;
    set_j(4'd1, 27'd1, 1'b0); xfer(2'd2, 32'h10000002);
    set_j(4'd2, 27'd2, 1'b0); xfer(2'd2, 32'h20000004);
    set_j(4'd3, 27'd3, 1'b0); xfer(2'd2, 32'h30000006);
    set_j(4'd4, 27'd4, 1'b0); xfer(2'd2, 32'h40000008);
    in_valid = 1'b1;
    base_addr = 27'h55; base_load = 1'b1;
    check("full_in_ready", {63'd0, in_ready}, 64'd0);
    check("full_idle", {63'd0, idle}, 64'd0);
    tick();
    in_valid = 1'b0; base_load = 1'b0;
    wc = wr_count;
    tick(); tick();
    check("busy_no_write", wr_count - wc, 64'd0);
    mem_busy = 1'b0;
    wait_idle();
    check("drain_count", wr_count - wc, 64'd4);
    check("drain_idle", {63'd0, idle}, 64'd1);

    // Invalid format: no write, fmt_err for one cycle
    wc = wr_count;
    xfer(2'd3, 32'd0);
    check("fmt_err_pulse", {63'd0, fmt_err}, 64'd1);
    tick();
    check("fmt_err_clear", {63'd0, fmt_err}, 64'd0);
    check("fmt3_idle", {63'd0, idle}, 64'd1);
`ifdef INSTR_ENC_ERRCNT_EN
    check("err_cnt_1", {56'd0, err_cnt}, 64'd1);
    for (int i = 0; i < 300; i++) xfer(2'd3, 32'd0);
    tick();
    check("err_cnt_sat", {56'd0, err_cnt}, 64'd255);
`endif
    check("fmt3_no_write", wr_count - wc, 64'd0);

    // Pointer wrap at the top of the address space
    base_addr = 27'h7FFFFFF; base_load = 1'b1; exp_ptr = 27'h7FFFFFF;
    tick();
    base_load = 1'b0;
    set_i(4'd5, 16'h1234, 4'd5, 4'd6, 4'd7); xfer(2'd1, 32'h51234567);
    set_i(4'd6, 16'hABCD, 4'd8, 4'd9, 4'hA); xfer(2'd1, 32'h6ABCD89A);
    wait_idle();
    check("wrap_drained", exp_q.size(), 64'd0);

    // Reset during WRITE with 3 words queued discards everything
    mem_busy = 1'b1;
    set_j(4'd7, 27'd7, 1'b1); xfer(2'd2, 32'h7000000F);
    set_j(4'd8, 27'd8, 1'b1); xfer(2'd2, 32'h80000011);
    set_j(4'd9, 27'd9, 1'b1); xfer(2'd2, 32'h90000013);
    check("pre_rst_we", {63'd0, mem_we}, 64'd1);
    wc = wr_count;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    check("rst_write_we", {63'd0, mem_we}, 64'd0);
    check("rst_write_idle", {63'd0, idle}, 64'd1);
    mem_busy = 1'b0;
    repeat (8) tick();
    check("rst_no_writes", wr_count - wc, 64'd0);

    // Pointer restarts at zero after reset
    exp_ptr = 27'd0;
    set_r(4'hF, 1'b0, 4'd0, 11'd1, 4'd0, 4'd0, 4'd1);
    xfer(2'd0, 32'hF0001001);
    wait_idle();
    check("final_queue_empty", exp_q.size(), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
